// File: rtl/alu_share_arbiter_pkg.sv
// ---------------------------------------------------------------------------
// alu_share_arbiter_pkg
// Shared definitions for the ALU sharing block: ALU operation codes (low four
// bits of the ALU control word), the sequencer state encoding and a helper
// that flags control codes the ALU does not implement.
// No ports (package).
// ---------------------------------------------------------------------------
package alu_share_arbiter_pkg;

  // Default widths used by the block and its interface.
  localparam int DEF_DATA_W = 32;
  localparam int DEF_OP_W   = 7;
  localparam int DEF_CNT_W  = 16;

  // ALU operation selects, encoded in alu_control[3:0].
  localparam logic [3:0] OP_ADD  = 4'd0;
  localparam logic [3:0] OP_SUB  = 4'd1;
  localparam logic [3:0] OP_XOR  = 4'd2;
  localparam logic [3:0] OP_OR   = 4'd3;
  localparam logic [3:0] OP_AND  = 4'd4;
  localparam logic [3:0] OP_SLL  = 4'd5;
  localparam logic [3:0] OP_SRL  = 4'd6;
  localparam logic [3:0] OP_SRA  = 4'd7;
  localparam logic [3:0] OP_SLT  = 4'd8;
  localparam logic [3:0] OP_SLTU = 4'd9;
  localparam logic [3:0] OP_LAST = OP_SLTU;

  // Sequencer states: waiting for work, ALU evaluating, result on offer.
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    RESP = 2'd2
  } state_t;

  // Any select above the last defined operation is not an ALU operation.
  function automatic logic op_is_illegal(input logic [3:0] sel);
    return (sel > OP_LAST);
  endfunction

endpackage : alu_share_arbiter_pkg

// File: rtl/alu_share_arbiter_if.sv
// ---------------------------------------------------------------------------
// alu_share_arbiter_if
// Bundles every non-clock signal of the ALU sharing block:
//   req0_* / req1_*  : valid/ready request channels (op, operand a, operand b)
//   alu_*            : control and operands to the ALU, result back from it
//   resp_*           : shared valid/ready response channel with id and error
//   grant_cnt0/1     : saturating accepted-op counters
// Modports:
//   slave  - the arbiter block itself
//   master - the surrounding environment (requesters, ALU, response consumer)
// ---------------------------------------------------------------------------
interface alu_share_arbiter_if #(
  parameter int DATA_W = 32,
  parameter int OP_W   = 7,
  parameter int CNT_W  = 16
);

  logic              req0_valid;
  logic              req0_ready;
  logic [OP_W-1:0]   req0_op;
  logic [DATA_W-1:0] req0_a;
  logic [DATA_W-1:0] req0_b;

  logic              req1_valid;
  logic              req1_ready;
  logic [OP_W-1:0]   req1_op;
  logic [DATA_W-1:0] req1_a;
  logic [DATA_W-1:0] req1_b;

  logic [OP_W-1:0]   alu_control;
  logic [DATA_W-1:0] alu_in1;
  logic [DATA_W-1:0] alu_in2;
  logic [DATA_W-1:0] alu_out;

  logic              resp_valid;
  logic              resp_ready;
  logic              resp_id;
  logic [DATA_W-1:0] resp_data;
  logic              resp_err;

  logic [CNT_W-1:0]  grant_cnt0;
  logic [CNT_W-1:0]  grant_cnt1;

  modport slave (
    input  req0_valid, req0_op, req0_a, req0_b,
    output req0_ready,
    input  req1_valid, req1_op, req1_a, req1_b,
    output req1_ready,
    output alu_control, alu_in1, alu_in2,
    input  alu_out,
    output resp_valid, resp_id, resp_data, resp_err,
    input  resp_ready,
    output grant_cnt0, grant_cnt1
  );

  modport master (
    output req0_valid, req0_op, req0_a, req0_b,
    input  req0_ready,
    output req1_valid, req1_op, req1_a, req1_b,
    input  req1_ready,
    input  alu_control, alu_in1, alu_in2,
    output alu_out,
    input  resp_valid, resp_id, resp_data, resp_err,
    output resp_ready,
    input  grant_cnt0, grant_cnt1
  );

endinterface : alu_share_arbiter_if

// File: rtl/alu_share_arbiter_rr_arbiter2.sv
// ---------------------------------------------------------------------------
// rr_arbiter2
// Two-way round-robin grant. When enabled, a lone request is granted outright;
// when both request, the one that did not win last time is granted. The
// last-grant register starts at 1 so requester 0 wins the first contention.
// Ports:
//   clk, reset : clock, asynchronous active-high reset
//   req[1:0]   : request vector (bit n = requester n)
//   en         : grants may be issued this cycle
//   gnt[1:0]   : one-hot grant, combinational from req/en
// ---------------------------------------------------------------------------
module rr_arbiter2 (
  input  logic       clk,
  input  logic       reset,
  input  logic [1:0] req,
  input  logic       en,
  output logic [1:0] gnt
);

  logic last_grant_reg;

  always_comb begin
    gnt = 2'b00;
    if (en) begin
      if (req == 2'b11) begin
        gnt = last_grant_reg ? 2'b01 : 2'b10;
      end else begin
        gnt = req;
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      last_grant_reg <= 1'b1;
    end else if (|gnt) begin
      last_grant_reg <= gnt[1];
    end
  end

endmodule : rr_arbiter2

// File: rtl/alu_share_arbiter.sv
// ---------------------------------------------------------------------------
// alu_share_arbiter
// Shares one combinational ALU between the execute stage (requester 0) and
// the address/branch-compare unit (requester 1). An accepted request is
// latched, presented to the ALU for one cycle, and the ALU result is captured
// and offered on a single response channel tagged with the requester id.
// A new request may be granted on the same cycle a response is taken, giving
// one op every two cycles when the consumer never stalls.
// Ports:
//   clk   : clock, rising edge
//   reset : asynchronous active-high reset
//   bus   : alu_share_arbiter_if.slave (request, ALU, response, counters)
// ---------------------------------------------------------------------------
module alu_share_arbiter
  import alu_share_arbiter_pkg::*;
#(
  parameter int DATA_W = DEF_DATA_W,
  parameter int OP_W   = DEF_OP_W,
  parameter int CNT_W  = DEF_CNT_W
) (
  input  logic                 clk,
  input  logic                 reset,
  alu_share_arbiter_if.slave   bus
);

  state_t state_reg;
  state_t state_next;

  logic [1:0]        req_vec;
  logic [1:0]        gnt;
  logic              grant_en;
  logic              accept;
  logic              accept_id;

  logic [OP_W-1:0]   op_reg;
  logic [DATA_W-1:0] a_reg;
  logic [DATA_W-1:0] b_reg;
  logic              id_reg;

  logic [DATA_W-1:0] resp_data_reg;
  logic              resp_id_reg;
  logic              resp_err_reg;
  logic              exec_illegal;

  logic [CNT_W-1:0]  cnt0_reg;
  logic [CNT_W-1:0]  cnt1_reg;

  // -------------------------------------------------------------------------
  // Arbitration. Grants are only possible while idle or on the cycle the
  // pending response is being taken. Gating with reset keeps the ready
  // outputs low while reset is held, even with a request present.
  // -------------------------------------------------------------------------
  assign req_vec = {bus.req1_valid, bus.req0_valid};

  always_comb begin
    grant_en = 1'b0;
    case (state_reg)
      IDLE:    grant_en = 1'b1;
      RESP:    grant_en = bus.resp_ready;
      default: grant_en = 1'b0;
    endcase
    grant_en = grant_en & ~reset;
  end

  rr_arbiter2 u_arb (
    .clk   (clk),
    .reset (reset),
    .req   (req_vec),
    .en    (grant_en),
    .gnt   (gnt)
  );

  assign accept    = |gnt;
  assign accept_id = gnt[1];

  // -------------------------------------------------------------------------
  // Sequencer
  // -------------------------------------------------------------------------
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_reg <= IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE: begin
        if (accept) begin
          state_next = EXEC;
        end
      end
      EXEC: begin
        state_next = RESP;
      end
      RESP: begin
        if (bus.resp_ready) begin
          state_next = accept ? EXEC : IDLE;
        end
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  // -------------------------------------------------------------------------
  // Request latch. These registers drive the ALU directly, so they simply
  // keep their last value whenever nothing is being accepted.
  // -------------------------------------------------------------------------
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      op_reg <= '0;
      a_reg  <= '0;
      b_reg  <= '0;
      id_reg <= 1'b0;
    end else if (accept) begin
      op_reg <= accept_id ? bus.req1_op : bus.req0_op;
      a_reg  <= accept_id ? bus.req1_a  : bus.req0_a;
      b_reg  <= accept_id ? bus.req1_b  : bus.req0_b;
      id_reg <= accept_id;
    end
  end

  // -------------------------------------------------------------------------
  // Result capture at the end of the EXEC cycle. An undefined op returns zero
  // data with the error flag instead of whatever the ALU produced.
  // -------------------------------------------------------------------------
  assign exec_illegal = op_is_illegal(op_reg[3:0]);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      resp_data_reg <= '0;
      resp_id_reg   <= 1'b0;
      resp_err_reg  <= 1'b0;
    end else if (state_reg == EXEC) begin
      resp_data_reg <= exec_illegal ? '0 : bus.alu_out;
      resp_id_reg   <= id_reg;
      resp_err_reg  <= exec_illegal;
    end
  end

  // -------------------------------------------------------------------------
  // Saturating accepted-op counters
  // -------------------------------------------------------------------------
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt0_reg <= '0;
    end else if (bus.req0_valid && gnt[0] && (cnt0_reg != {CNT_W{1'b1}})) begin
      cnt0_reg <= cnt0_reg + 1'b1;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt1_reg <= '0;
    end else if (bus.req1_valid && gnt[1] && (cnt1_reg != {CNT_W{1'b1}})) begin
      cnt1_reg <= cnt1_reg + 1'b1;
    end
  end

  // -------------------------------------------------------------------------
  // Outputs. resp_valid comes from the state register only, so it never
  // depends combinationally on resp_ready.
  // -------------------------------------------------------------------------
  assign bus.req0_ready  = gnt[0];
  assign bus.req1_ready  = gnt[1];

  assign bus.alu_control = op_reg;
  assign bus.alu_in1     = a_reg;
  assign bus.alu_in2     = b_reg;

  assign bus.resp_valid  = (state_reg == RESP);
  assign bus.resp_data   = resp_data_reg;
  assign bus.resp_id     = resp_id_reg;
  assign bus.resp_err    = resp_err_reg;

  assign bus.grant_cnt0  = cnt0_reg;
  assign bus.grant_cnt1  = cnt1_reg;

endmodule : alu_share_arbiter

// File: doc/alu_share_arbiter.md
Name: alu_share_arbiter

Overview:
- Shares the single combinational ALU between two requesters: requester 0 is the execute stage, requester 1 is the address/branch-compare unit.
- Each requester uses a valid/ready request channel. The block grants requests round-robin, drives the ALU control and operand inputs from registered copies, and captures the ALU output.
- It returns the result on one shared response channel, tagged with the requester id.
- Sits between the pipeline front end and the ALU; the ALU itself is unchanged.

Parameters:
- DATA_W, 32, operand/result width
- OP_W, 7, ALU control width (only bits [3:0] select the operation)
- CNT_W, 16, width of the saturating per-requester grant counters

Ports:
- clk  input  1  system clock, rising edge
- reset  input  1  asynchronous, active-high reset
- req0_valid  input  1  requester 0 has an operation
- req0_ready  output  1  requester 0 operation accepted this cycle
- req0_op  input  OP_W  ALU control code
- req0_a  input  DATA_W  operand 1
- req0_b  input  DATA_W  operand 2
- req1_valid, req1_ready, req1_op, req1_a, req1_b  same as above for requester 1
- alu_control  output  OP_W  to ALU control
- alu_in1  output  DATA_W  to ALU input1
- alu_in2  output  DATA_W  to ALU input2
- alu_out  input  DATA_W  from ALU out
- resp_valid  output  1  result available
- resp_ready  input  1  consumer takes result
- resp_id  output  1  requester that issued the result
- resp_data  output  DATA_W  result
- resp_err  output  1  op code illegal (op[3:0] > 9)
- grant_cnt0  output  CNT_W  saturating accepted-op count, requester 0
- grant_cnt1  output  CNT_W  saturating accepted-op count, requester 1

Behaviour:
- Reset (asynchronous, active-high) forces:
  - state IDLE; all outputs 0; operand/op registers 0; counters 0.
  - last_grant = 1, so requester 0 wins the first contention.
  - Any in-flight op is discarded with no response.
- FSM states:
  - IDLE: if any reqN_valid, grant one, assert its reqN_ready combinationally, latch op/a/b/id, go to EXEC.
  - EXEC: alu_control/alu_in1/alu_in2 driven from the latched registers. At the clock edge, capture alu_out into resp_data and resp_id from the latch, then go to RESP. If op[3:0] > 9, resp_data = 0 and resp_err = 1.
  - RESP: resp_valid = 1; resp_data/resp_id/resp_err held stable until resp_ready.
    - On handshake with no valid request: go to IDLE.
    - On handshake with a valid request: grant it that same cycle and go to EXEC (back-to-back).
- Arbitration:
  - Only one reqN_ready is ever high, and only in IDLE or on a RESP handshake cycle.
  - Both valid: grant the requester that is not last_grant; last_grant updates to the granted id.
  - Single valid: grant it regardless of last_grant.
- Requesters hold valid and payload stable until ready. Deasserting valid before ready is allowed and is simply not granted.
- Latency: accept in cycle T, result captured at end of T+1, resp_valid from T+2. Sustained throughput is 1 op per 2 cycles with resp_ready held high.
- alu_control/alu_in1/alu_in2 hold their last latched values outside EXEC; they are don't-care to the ALU but must be stable.
- grant_cntN increments on each reqN_valid & reqN_ready and saturates at all-ones (no wrap).
- No combinational path from resp_ready to resp_valid. reqN_ready may depend combinationally on resp_ready and reqN_valid.

Decomposition:
- Shared package/header `alu_defs`:
  - ALU op constants ADD=0, SUB=1, XOR=2, OR=3, AND=4, SLL=5, SRL=6, SRA=7, SLT=8, SLTU=9, OP_LAST=9.
  - FSM state encodings IDLE/EXEC/RESP.
- One natural sub-module: `rr_arbiter2`, a 2-way round-robin grant with last_grant register. Counters and FSM stay inline.

Test Plan:
- Single request: req0 op=0 (ADD), a=4, b=4 → req0_ready in cycle T; resp_valid at T+2 with resp_data=8, resp_id=0, resp_err=0.
- Contention: both valid from reset; req0 SUB 10−3, req1 SLTU a=1, b=0xFFFFFFFF; resp_ready=1 → responses in order id0=7, then id1=1; grants alternate 0,1,0,1 over 4 ops each side; grant_cnt0 = grant_cnt1 = 4.
- Backpressure: resp_ready=0 for 5 cycles after resp_valid with SRA a=0x80000001, b=1 → resp_data=0xC0000000 held stable, no reqN_ready during the stall. On release, a pending req1 is accepted in the same cycle.
- Illegal op: req1 op=12, a=5, b=6 → resp_err=1, resp_data=0, resp_id=1; the next legal op has resp_err=0.
- Reset mid-op: assert reset during EXEC → all outputs 0 immediately (asynchronous). After release, no stale response; the next req0 gets priority.
- Counter saturation: force grant_cnt0 to 0xFFFE, issue 3 req0 ops → count ends at 0xFFFF with no wrap.
